pkt_register_gen: RTL

Parametrised, self-sequenced successor to the router's packet register stage. It accepts a header/payload/parity byte stream from the router input and forwards header and payload to the destination FIFO write port. A HOLD_DEPTH-entry hold buffer absorbs bytes while that FIFO is full. The block computes and checks packet parity, and optionally checks payload length. It needs no external FSM state inputs.

---
 rtl/pkt_register_gen.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pkt_register_gen.sv
// pkt_register_gen: router packet register stage with hold buffer and
// parity / optional payload-length checking. Optional: PKT_REG_LEN_CHECK_EN.
// Ports: clk, rst (async active-low), pkt_valid, din, fifo_full in;
//        din_ready, dout, dout_valid, dst_addr, parity_done, error,
//        len_error out.
module pkt_register_gen #(
    parameter int DW         = 8,
    parameter int HOLD_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pkt_valid,
    input  logic [DW-1:0] din,
    input  logic          fifo_full,
    output logic          din_ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic [1:0]    dst_addr,
    output logic          parity_done,
    output logic          error,
    output logic          len_error
);

    localparam int CW = $clog2(HOLD_DEPTH + 1);
    localparam int LW = DW - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CHECK
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_buf [HOLD_DEPTH];
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_par;
    logic [DW-1:0] r_pkt_par;

    logic [DW-1:0] w_buf_nxt [HOLD_DEPTH];
    logic [CW-1:0] w_cnt_nxt;
    logic          w_acc;
    logic          w_fwd;
    logic          w_wr;
    logic          w_buf_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_load_din;
    logic          w_hdr;
    logic          w_pl;
    logic          w_done;

    // Held low during reset so every output reads 0 while rst is asserted.
    assign din_ready   = rst && (r_state != S_CHECK)
                         && (r_cnt != CW'(HOLD_DEPTH));
    assign w_acc       = din_ready
                         && ((r_state == S_PAYLOAD)
                             || (r_state == S_IDLE && pkt_valid));
    assign w_fwd       = w_acc && pkt_valid;
    assign w_wr        = dout_valid && !fifo_full;
    assign w_buf_empty = (r_cnt == '0);
    assign w_pop       = w_wr && !w_buf_empty;
    // din must queue behind older bytes, or wait if the output is stuck.
    assign w_push      = w_fwd
                         && (!w_buf_empty || (dout_valid && !w_wr));
    assign w_load_din  = w_fwd && !w_push;
    assign w_hdr       = (r_state == S_IDLE) && w_acc;
    assign w_pl        = (r_state == S_PAYLOAD) && w_fwd;
    assign w_done      = (r_state == S_CHECK) && w_buf_empty && !dout_valid;

    always_comb begin
        w_buf_nxt = r_buf;
        w_cnt_nxt = r_cnt;
        if (w_pop) begin
            for (int i = 0; i < HOLD_DEPTH - 1; i++) begin
                w_buf_nxt[i] = r_buf[i+1];
            end
            w_cnt_nxt = r_cnt - CW'(1);
        end
        if (w_push) begin
            for (int i = 0; i < HOLD_DEPTH; i++) begin
                if (CW'(i) == w_cnt_nxt) begin
                    w_buf_nxt[i] = din;
                end
            end
            w_cnt_nxt = w_cnt_nxt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            for (int i = 0; i < HOLD_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_cnt <= w_cnt_nxt;
            r_buf <= w_buf_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (w_wr || !dout_valid) begin
            if (w_pop) begin
                dout       <= r_buf[0];
                dout_valid <= 1'b1;
            end else if (w_load_din) begin
                dout       <= din;
                dout_valid <= 1'b1;
            end else begin
                dout_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_par       <= '0;
            r_pkt_par   <= '0;
            dst_addr    <= '0;
            parity_done <= 1'b0;
            error       <= 1'b0;
        end else begin
            parity_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_hdr) begin
                        dst_addr <= din[1:0];
                        r_par    <= din;
                        error    <= 1'b0;
                        r_state  <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (w_pl) begin
                        r_par <= r_par ^ din;
                    end else if (w_acc) begin
                        r_pkt_par <= din;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_done) begin
                        parity_done <= 1'b1;
                        error       <= (r_pkt_par != r_par);
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PKT_REG_LEN_CHECK_EN
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_pl_cnt;
    logic          r_len_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len     <= '0;
            r_pl_cnt  <= '0;
            r_len_err <= 1'b0;
        end else if (w_hdr) begin
            r_len     <= din[DW-1:2];
            r_pl_cnt  <= '0;
            r_len_err <= 1'b0;
        end else if (w_pl) begin
            r_pl_cnt <= r_pl_cnt + LW'(1);
        end else if (w_done) begin
            r_len_err <= (r_pl_cnt != r_len);
        end
    end

    assign len_error = r_len_err;
`else
    assign len_error = 1'b0;
`endif

endmodule
